adder_result_accumulator: RTL and testbench

ADDER_RESULT_ACCUMULATOR -- requirements
Module: adder_result_accumulator

---
 rtl/adder_result_accumulator.sv | 112 +++++++++++
 tb/tb_adder_result_accumulator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/adder_result_accumulator.sv
// Sums bursts of 5-bit {cout,sum} adder results into a 9-bit total and
// presents each burst result with a valid/ready handshake.
module adder_result_accumulator #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] sum,
    input  logic       cout,
    input  logic       flush,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out_total,
    output logic [4:0] out_count,
    output logic       out_partial
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [4:0] BURST_CNT = 5'(BURST_LEN);

    state_t     state_q, state_d;
    logic [8:0] acc_q, acc_d;
    logic [4:0] cnt_q, cnt_d;
    logic [8:0] total_q, total_d;
    logic [4:0] count_q, count_d;
    logic       partial_q, partial_d;

    logic       accept;
    logic [4:0] sample;
    logic [8:0] acc_sum;
    logic [4:0] cnt_sum;
    logic       close;

    // acc_sum/cnt_sum already include this cycle's sample, so a burst closed
    // by flush on the same cycle as an accept reports that sample too.
    assign sample  = {cout, sum};
    assign accept  = in_valid && (state_q == ACCUM);
    assign acc_sum = acc_q + (accept ? {4'd0, sample} : 9'd0);
    assign cnt_sum = cnt_q + {4'd0, accept};
    assign close   = (state_q == ACCUM) &&
                     ((cnt_sum == BURST_CNT) || (flush && (cnt_sum != 5'd0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (close)     state_d = HOLD;
            HOLD:    if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Handshake outputs decode the registered state only: no input-to-output path.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        total_d   = total_q;
        count_d   = count_q;
        partial_d = partial_q;
        if (state_q == ACCUM) begin
            acc_d = acc_sum;
            cnt_d = cnt_sum;
            if (close) begin
                total_d   = acc_sum;
                count_d   = cnt_sum;
                partial_d = (cnt_sum < BURST_CNT);
            end
        end else if (out_ready) begin
            acc_d = 9'd0;
            cnt_d = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= 9'd0;
            cnt_q     <= 5'd0;
            total_q   <= 9'd0;
            count_q   <= 5'd0;
            partial_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            total_q   <= total_d;
            count_q   <= count_d;
            partial_q <= partial_d;
        end
    end

    assign out_total   = total_q;
    assign out_count   = count_q;
    assign out_partial = partial_q;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed and randomized checks of adder_result_accumulator (BURST_LEN 4 and 16)
// against a plain-arithmetic burst model.
module tb_adder_result_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v4, f4, r4, v16, f16, r16;
    logic [4:0] s4, s16;
    logic       ir4, ov4, p4, ir16, ov16, p16;
    logic [8:0] t4, t16;
    logic [4:0] c4, c16;

    adder_result_accumulator #(.BURST_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .sum(s4[3:0]), .cout(s4[4]),
        .flush(f4), .in_ready(ir4), .out_valid(ov4), .out_ready(r4),
        .out_total(t4), .out_count(c4), .out_partial(p4)
    );

    adder_result_accumulator #(.BURST_LEN(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .sum(s16[3:0]), .cout(s16[4]),
        .flush(f16), .in_ready(ir16), .out_valid(ov16), .out_ready(r16),
        .out_total(t16), .out_count(c16), .out_partial(p16)
    );

    int checks = 0;
    int fails  = 0;

    // Model state per instance: running sum/count of the open burst and the held result.
    bit m4_hold, m4_part, m16_hold, m16_part;
    int m4_acc, m4_cnt, m4_tot, m4_num;
    int m16_acc, m16_cnt, m16_tot, m16_num;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int bl, input bit rs, input bit v, input bit f,
                              input bit r, input int smp,
                              inout bit hold, inout int acc, inout int cnt,
                              inout int tot, inout int num, inout bit part);
        if (rs) begin
            hold = 0; acc = 0; cnt = 0; tot = 0; num = 0; part = 0;
        end else if (!hold) begin
            if (v) begin
                acc += smp;
                cnt++;
            end
            if (cnt == bl || (f && cnt > 0)) begin
                tot = acc; num = cnt; part = (cnt < bl); hold = 1;
                acc = 0; cnt = 0;
            end
        end else if (r) begin
            hold = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(4, rst, v4, f4, r4, int'(s4), m4_hold, m4_acc, m4_cnt, m4_tot, m4_num, m4_part);
        model_step(16, rst, v16, f16, r16, int'(s16), m16_hold, m16_acc, m16_cnt, m16_tot, m16_num, m16_part);
        #1;
        check("in_ready4", ir4, !m4_hold);
        check("out_valid4", ov4, m4_hold);
        if (m4_hold) begin
            check("out_total4", t4, m4_tot);
            check("out_count4", c4, m4_num);
            check("out_partial4", p4, m4_part);
        end
        check("in_ready16", ir16, !m16_hold);
        check("out_valid16", ov16, m16_hold);
        if (m16_hold) begin
            check("out_total16", t16, m16_tot);
            check("out_count16", c16, m16_num);
            check("out_partial16", p16, m16_part);
        end
    endtask

    task automatic drive4(input bit v, input int smp, input bit f, input bit r);
        v4 = v; s4 = 5'(smp); f4 = f; r4 = r;
    endtask

    initial begin
        rst = 1'b1;
        drive4(0, 0, 0, 1);
        v16 = 0; s16 = 0; f16 = 0; r16 = 1;
        tick();
        check("rst_valid", ov4, 0);
        check("rst_ready", ir4, 1);
        check("rst_total", t4, 0);
        check("rst_count", c4, 0);
        check("rst_partial", p4, 0);
        rst = 1'b0;

        // Full burst of four: 21+3+31+1
        drive4(1, 21, 0, 1); tick();
        drive4(1, 3, 0, 1);  tick();
        drive4(1, 31, 0, 1); tick();
        check("no_early_valid", ov4, 0);
        drive4(1, 1, 0, 1);  tick();
        check("burst_valid", ov4, 1);
        check("burst_total", t4, 56);
        check("burst_count", c4, 4);
        check("burst_partial", p4, 0);
        drive4(0, 0, 0, 1);  tick();
        check("burst_one_cycle", ov4, 0);

        // Partial burst closed by flush with no sample that cycle
        drive4(1, 7, 0, 1); tick();
        drive4(1, 9, 0, 1); tick();
        drive4(0, 0, 1, 1); tick();
        check("flush_total", t4, 16);
        check("flush_count", c4, 2);
        check("flush_partial", p4, 1);
        drive4(0, 0, 0, 1); tick();
        drive4(0, 0, 1, 1); tick(); tick();
        check("empty_flush_ignored", ov4, 0);

        // Backpressure: result holds, inputs refused
        for (int i = 0; i < 4; i++) begin
            drive4(1, 10 + i, 0, 0); tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive4(1, 31, (i == 2), 0); tick();
            check("bp_total", t4, 46);
            check("bp_ready", ir4, 0);
        end
        drive4(0, 0, 0, 1); tick();
        for (int i = 0; i < 4; i++) begin
            drive4(1, 2, 0, 1); tick();
        end
        check("fresh_total", t4, 8);
        check("fresh_count", c4, 4);

        // Reset mid-burst discards partial sum
        drive4(0, 0, 0, 1); tick();
        for (int i = 0; i < 3; i++) begin
            drive4(1, 30, 0, 1); tick();
        end
        drive4(1, 30, 0, 1); rst = 1'b1; tick();
        rst = 1'b0;
        check("rst_mid_ready", ir4, 1);
        for (int i = 0; i < 4; i++) begin
            drive4(1, 2, 0, 0); tick();
        end
        check("post_rst_total", t4, 8);
        check("post_rst_count", c4, 4);
        rst = 1'b1; tick();
        check("rst_hold_valid", ov4, 0);
        rst = 1'b0;

        // Flush together with an accepted third sample
        drive4(1, 1, 0, 1); tick();
        drive4(1, 2, 0, 1); tick();
        drive4(1, 3, 1, 1); tick();
        check("flush_acc_total", t4, 6);
        check("flush_acc_count", c4, 3);
        check("flush_acc_partial", p4, 1);
        drive4(0, 0, 0, 1); tick();

        // Sixteen maximal samples: no wrap
        for (int i = 0; i < 16; i++) begin
            v16 = 1; s16 = 5'd31; tick();
        end
        check("max_total", t16, 496);
        check("max_count", c16, 16);
        check("max_partial", p16, 0);
        v16 = 0; tick();

        // Randomized traffic on both instances
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive4($urandom_range(0, 3) != 0, $urandom_range(0, 31),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
            v16 = ($urandom_range(0, 3) != 0);
            s16 = 5'($urandom_range(0, 31));
            f16 = ($urandom_range(0, 31) == 0);
            r16 = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
